// File: rtl/cache_pkg.sv
// Shared types and default geometry for the single-line instruction cache controller.
package cache_pkg;

  localparam int N_CACHELINE_LENGTH_DEF = 4;
  localparam int BITSIZE_DEF            = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    REFILL  = 3'd2,
    COMMIT  = 3'd3,
    RESPOND = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/icache_ctrl_if.sv
// Core, cache-line and memory signals of the icache controller; master = controller side.
interface icache_ctrl_if import cache_pkg::*; #(
  parameter int N_CACHELINE_LENGTH = N_CACHELINE_LENGTH_DEF,
  parameter int BITSIZE            = BITSIZE_DEF
);

  logic                              core_req_i;
  logic [BITSIZE-1:0]                core_addr_i;
  logic                              core_ack_o;
  logic [BITSIZE-1:0]                core_data_o;

  logic [BITSIZE-1:0]                line_addr_o;
  logic                              line_store_o;
  logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_data_o;
  logic                              line_hit_i;
  logic [BITSIZE-1:0]                line_data_i;

  logic                              mem_req_o;
  logic [BITSIZE-1:0]                mem_addr_o;
  logic                              mem_valid_i;
  logic [BITSIZE-1:0]                mem_data_i;

  modport master (
    input  core_req_i, core_addr_i, line_hit_i, line_data_i, mem_valid_i, mem_data_i,
    output core_ack_o, core_data_o, line_addr_o, line_store_o, line_data_o, mem_req_o, mem_addr_o
  );

  modport slave (
    output core_req_i, core_addr_i, line_hit_i, line_data_i, mem_valid_i, mem_data_i,
    input  core_ack_o, core_data_o, line_addr_o, line_store_o, line_data_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/cache_refill_buf.sv
// N-word refill staging buffer: one word written per cycle, whole line visible flat; write lands next edge.
module cache_refill_buf #(
  parameter int N_WORDS = 4,
  parameter int WORD_W  = 32
) (
  input  logic                        clk,
  input  logic                        rstn_i,
  input  logic                        we_i,
  input  logic [$clog2(N_WORDS)-1:0]  idx_i,
  input  logic [WORD_W-1:0]           dat_i,
  output logic [WORD_W*N_WORDS-1:0]   line_o
);

  logic [WORD_W-1:0] word_q [N_WORDS];

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < N_WORDS; i++) word_q[i] <= '0;
    end else if (we_i) begin
      word_q[idx_i] <= dat_i;
    end
  end

  for (genvar g = 0; g < N_WORDS; g++) begin : g_flat
    assign line_o[g*WORD_W +: WORD_W] = word_q[g];
  end

endmodule

// File: rtl/icache_ctrl.sv
// Single-line icache sequencer: hit ack 2 cycles after request, miss refills the whole line first.
// No backpressure on the core beyond holding the ack; memory stalls simply stretch REFILL.
module icache_ctrl import cache_pkg::*; #(
  parameter int N_CACHELINE_LENGTH = N_CACHELINE_LENGTH_DEF,
  parameter int BITSIZE            = BITSIZE_DEF
) (
  input  logic          clk,
  input  logic          rstn_i,
  icache_ctrl_if.master bus
);

  localparam int OFFSET_W = $clog2(N_CACHELINE_LENGTH);
  localparam int TAG_W    = BITSIZE - OFFSET_W;
  localparam logic [OFFSET_W-1:0] CNT_LAST = OFFSET_W'(N_CACHELINE_LENGTH - 1);

  ctrl_state_t                  state_q, state_d;
  logic [BITSIZE-1:0]           addr_q, addr_d;
  logic [BITSIZE-1:0]           core_data_q, core_data_d;
  logic [OFFSET_W-1:0]          cnt_q, cnt_d;
  logic                         valid_line_q, valid_line_d;
  logic                         buf_we;
  logic [BITSIZE*N_CACHELINE_LENGTH-1:0] buf_line;
  logic [TAG_W-1:0]             tag;
  logic [BITSIZE-1:0]           buf_word;

  assign tag      = addr_q[BITSIZE-1:OFFSET_W];
  assign buf_word = buf_line[addr_q[OFFSET_W-1:0]*BITSIZE +: BITSIZE];

  cache_refill_buf #(
    .N_WORDS (N_CACHELINE_LENGTH),
    .WORD_W  (BITSIZE)
  ) u_buf (
    .clk    (clk),
    .rstn_i (rstn_i),
    .we_i   (buf_we),
    .idx_i  (cnt_q),
    .dat_i  (bus.mem_data_i),
    .line_o (buf_line)
  );

  assign bus.line_data_o = buf_line;
  assign bus.core_data_o = core_data_q;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      core_data_q  <= '0;
      cnt_q        <= '0;
      valid_line_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      core_data_q  <= core_data_d;
      cnt_q        <= cnt_d;
      valid_line_q <= valid_line_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    core_data_d      = core_data_q;
    cnt_d            = cnt_q;
    valid_line_d     = valid_line_q;
    buf_we           = 1'b0;
    bus.core_ack_o   = 1'b0;
    bus.line_addr_o  = '0;
    bus.line_store_o = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_addr_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.core_req_i) begin
          addr_d  = bus.core_addr_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.line_addr_o = addr_q;
        // The line's tag compare is meaningless until something has been stored in it.
        if (bus.line_hit_i && valid_line_q) begin
          core_data_d = bus.line_data_i;
          state_d     = RESPOND;
        end else begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {tag, cnt_q};
        if (bus.mem_valid_i) begin
          buf_we = 1'b1;
          if (cnt_q == CNT_LAST) state_d = COMMIT;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        bus.line_store_o = 1'b1;
        bus.line_addr_o  = {tag, {OFFSET_W{1'b0}}};
        core_data_d      = buf_word;
        valid_line_d     = 1'b1;
        state_d          = RESPOND;
      end
      RESPOND: begin
        bus.core_ack_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a behavioural memory and cache-line model.
module tb_icache_ctrl;
  import cache_pkg::*;

  logic clk;
  logic rstn;

  icache_ctrl_if #(.N_CACHELINE_LENGTH(4), .BITSIZE(32)) bus ();

  icache_ctrl #(.N_CACHELINE_LENGTH(4), .BITSIZE(32)) dut (
    .clk    (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // memory model state
  int          lat;
  int          wcnt;
  bit          spur;
  int          req_cyc;
  int          stores;
  logic [31:0] addr_log[$];
  logic [127:0] last_store;

  // cache-line model
  bit          force_hit;
  bit          mdl_vld;
  logic [29:0] mdl_tag;
  logic [127:0] mdl_line;

  assign bus.line_hit_i  = force_hit | (mdl_vld && (bus.line_addr_o[31:2] == mdl_tag));
  assign bus.line_data_i = force_hit ? 32'h0000_0BAD : mdl_line[bus.line_addr_o[1:0]*32 +: 32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h41) return 32'hA0 + {30'h0, a[1:0]};
    return 32'hD000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory answers after `lat` wait cycles; everything observed here is captured at the next posedge.
  initial begin
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;
    wcnt = 0; req_cyc = 0; stores = 0; mdl_vld = 0; mdl_tag = '0; mdl_line = '0; last_store = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_o) begin
        req_cyc++;
        if (wcnt >= lat) begin
          bus.mem_valid_i = 1'b1;
          bus.mem_data_i  = mem_word(bus.mem_addr_o);
          addr_log.push_back(bus.mem_addr_o);
          wcnt = 0;
        end else begin
          bus.mem_valid_i = 1'b0;
          bus.mem_data_i  = '0;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        bus.mem_valid_i = spur;
        bus.mem_data_i  = spur ? 32'hDEAD_BEEF : 32'h0;
      end
      if (bus.line_store_o) begin
        stores++;
        mdl_vld    = 1'b1;
        mdl_tag    = bus.line_addr_o[31:2];
        mdl_line   = bus.line_data_o;
        last_store = bus.line_data_o;
      end
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    req_cyc = 0;
    stores  = 0;
  endtask

  task automatic wait_ack(input string tag, input int drop_at,
                          output logic [31:0] d, output int cyc);
    bit got;
    got = 1'b0; d = '0; cyc = 0;
    for (int n = 1; n <= 400 && !got; n++) begin
      @(negedge clk);
      if (bus.core_ack_o) begin
        got = 1'b1;
        d   = bus.core_data_o;
        cyc = n;
      end
      if (n == drop_at) bus.core_req_i = 1'b0;
    end
    chk({tag, "_ack"}, 128'(got), 128'(1));
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input int drop_at,
                       output logic [31:0] d, output int cyc);
    clear_logs();
    bus.core_addr_i = a;
    bus.core_req_i  = 1'b1;
    wait_ack(tag, drop_at, d, cyc);
    bus.core_req_i = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 128'(bus.core_ack_o), 128'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_memreq"},  128'(bus.mem_req_o),    128'(0));
    chk({tag, "_memaddr"}, 128'(bus.mem_addr_o),   128'(0));
    chk({tag, "_ack"},     128'(bus.core_ack_o),   128'(0));
    chk({tag, "_store"},   128'(bus.line_store_o), 128'(0));
    chk({tag, "_laddr"},   128'(bus.line_addr_o),  128'(0));
    chk({tag, "_cdata"},   128'(bus.core_data_o),  128'(0));
    chk({tag, "_ldata"},   bus.line_data_o,        128'(0));
  endtask

  initial begin
    logic [31:0] d;
    int          cyc;
    bit          seen;

    rstn = 1'b0;
    bus.core_req_i = 1'b0;
    bus.core_addr_i = '0;
    force_hit = 1'b0;
    spur = 1'b0;
    lat = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 6: spurious memory data while idle and a stale hit before any refill
    spur = 1'b1;
    force_hit = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("t6_nocapture", bus.line_data_o, 128'(0));
    chk("t6_noack", 128'(bus.core_ack_o), 128'(0));

    // 1: cold miss with a forced stale hit that must be ignored
    fetch("t1", 32'h105, -1, d, cyc);
    force_hit = 1'b0;
    chk("t1_words", 128'(addr_log.size()), 128'(4));
    for (int i = 0; i < addr_log.size(); i++)
      chk($sformatf("t1_maddr%0d", i), 128'(addr_log[i]), 128'(32'h104 + i));
    chk("t1_stores", 128'(stores), 128'(1));
    chk("t1_line", last_store, 128'h000000A3_000000A2_000000A1_000000A0);
    chk("t1_data", 128'(d), 128'(32'hA1));

    // 2: hit on the committed line
    fetch("t2", 32'h107, -1, d, cyc);
    chk("t2_words", 128'(addr_log.size()), 128'(0));
    chk("t2_memreq", 128'(req_cyc), 128'(0));
    chk("t2_lat", 128'(cyc), 128'(2));
    chk("t2_data", 128'(d), 128'(32'hA3));

    // 3: new tag, 3 wait cycles per word, request dropped mid-refill
    lat = 3;
    fetch("t3", 32'h200, 4, d, cyc);
    chk("t3_words", 128'(addr_log.size()), 128'(4));
    chk("t3_reqcyc", 128'(req_cyc), 128'(16));
    chk("t3_stores", 128'(stores), 128'(1));
    chk("t3_data", 128'(d), 128'(32'hD000_0200));

    // 4: reset while the third word is outstanding
    lat = 1;
    clear_logs();
    bus.core_addr_i = 32'h300;
    bus.core_req_i  = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (addr_log.size() >= 2) seen = 1'b1;
    end
    chk("t4_progress", 128'(seen), 128'(1));
    @(posedge clk);
    #2;
    rstn = 1'b0;
    bus.core_req_i = 1'b0;
    #1;
    chk_outputs_zero("t4_rst");
    repeat (2) @(negedge clk);
    chk("t4_nostore", 128'(stores), 128'(0));
    rstn = 1'b1;
    @(negedge clk);
    fetch("t4b", 32'h203, -1, d, cyc);
    chk("t4b_words", 128'(addr_log.size()), 128'(4));
    chk("t4b_data", 128'(d), 128'(32'hD000_0203));
    fetch("t4c", 32'h302, -1, d, cyc);
    chk("t4c_words", 128'(addr_log.size()), 128'(4));
    if (addr_log.size() > 0) chk("t4c_base", 128'(addr_log[0]), 128'(32'h300));
    chk("t4c_data", 128'(d), 128'(32'hD000_0302));

    // 5: held request, address changed during refill, back-to-back
    lat = 0;
    clear_logs();
    bus.core_addr_i = 32'h105;
    bus.core_req_i  = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (addr_log.size() >= 1) seen = 1'b1;
    end
    bus.core_addr_i = 32'h306;
    wait_ack("t5a", -1, d, cyc);
    chk("t5a_data", 128'(d), 128'(32'hA1));
    clear_logs();
    @(negedge clk);
    chk("t5_pulse", 128'(bus.core_ack_o), 128'(0));
    wait_ack("t5b", -1, d, cyc);
    bus.core_req_i = 1'b0;
    chk("t5b_data", 128'(d), 128'(32'hD000_0306));
    chk("t5b_words", 128'(addr_log.size()), 128'(4));
    if (addr_log.size() > 0) chk("t5b_base", 128'(addr_log[0]), 128'(32'h304));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
